// File: rtl/button_event_port.sv
// button_event_port: rising-edge sticky event flags with W1C, overrun tracking, mask and level irq over a 4-register CPU port
module button_event_port #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level_in,
  input  logic [1:0]       addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             irq
);
  logic             armed;
  logic [WIDTH-1:0] prevLevel, eventReg, maskReg, overrunReg;
  logic [WIDTH-1:0] edgeDet, eventClr, overrunClr;
  logic [WIDTH-1:0] eventNext, overrunNext, maskNext, rdMux;
  always_comb begin
    // armed stays low for the first clock so keys held through reset never fire
    edgeDet     = armed ? (level_in & ~prevLevel) : '0;
    eventClr    = (wr_en && addr == 2'd1) ? wr_data : '0;
    overrunClr  = (wr_en && addr == 2'd3) ? wr_data : '0;
    eventNext   = (eventReg & ~eventClr) | edgeDet;
    overrunNext = (overrunReg & ~overrunClr) | (edgeDet & eventReg & ~eventClr);
    maskNext    = (wr_en && addr == 2'd2) ? wr_data : maskReg;
    rdMux       = addr == 2'd0 ? prevLevel :
                  addr == 2'd1 ? eventReg  :
                  addr == 2'd2 ? maskReg   : overrunReg;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed      <= 1'b0;
      prevLevel  <= '0;
      eventReg   <= '0;
      maskReg    <= '0;
      overrunReg <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      armed      <= 1'b1;
      prevLevel  <= level_in;
      eventReg   <= eventNext;
      maskReg    <= maskNext;
      overrunReg <= overrunNext;
      irq        <= |(eventNext & maskNext);
      rd_valid   <= rd_en;
      if (rd_en) rd_data <= rdMux;
    end
endmodule

// File: tb/tb_button_event_port.sv
// tb_button_event_port: directed scenario tasks with hand-computed expectations for button_event_port
module tb_button_event_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] level_in = 16'h0001;
  logic [1:0]  addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        irq;
  int nCmp = 0;
  int nErr = 0;

  button_event_port #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [1:0] a, input logic [15:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic doRead(input logic [1:0] a, output logic [15:0] d, output logic v);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data; v = rd_valid;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic v;
    #2;
    nCmp++; if (rd_data !== 16'h0) begin nErr++; $display("FAIL reset_rd_data got %h want %h", rd_data, 16'h0); end
    nCmp++; if (rd_valid !== 1'b0) begin nErr++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    nCmp++; if (irq !== 1'b0) begin nErr++; $display("FAIL reset_irq got %b want 0", irq); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    doRead(2'd1, d, v);
    nCmp++; if (d !== 16'h0) begin nErr++; $display("FAIL held_key_event got %h want %h", d, 16'h0); end
    nCmp++; if (irq !== 1'b0) begin nErr++; $display("FAIL held_key_irq got %b want 0", irq); end
    doRead(2'd0, d, v);
    nCmp++; if (d !== 16'h0001) begin nErr++; $display("FAIL level_read got %h want %h", d, 16'h0001); end
  endtask

  task automatic test_edge_capture();
    logic [15:0] d;
    logic v;
    level_in = 16'h0000; tick();
    level_in = 16'h0010; tick();
    level_in = 16'h0000; tick(); tick();
    doRead(2'd1, d, v);
    nCmp++; if (v !== 1'b1) begin nErr++; $display("FAIL read_valid got %b want 1", v); end
    nCmp++; if (d !== 16'h0010) begin nErr++; $display("FAIL event_sticky got %h want %h", d, 16'h0010); end
    tick();
    nCmp++; if (rd_valid !== 1'b0) begin nErr++; $display("FAIL valid_one_cycle got %b want 0", rd_valid); end
    nCmp++; if (rd_data !== 16'h0010) begin nErr++; $display("FAIL rd_data_hold got %h want %h", rd_data, 16'h0010); end
    doRead(2'd1, d, v);
    nCmp++; if (d !== 16'h0010) begin nErr++; $display("FAIL read_no_side_effect got %h want %h", d, 16'h0010); end
  endtask

  task automatic test_irq();
    doWrite(2'd1, 16'h0010);
    doWrite(2'd2, 16'h0010);
    nCmp++; if (irq !== 1'b0) begin nErr++; $display("FAIL irq_idle got %b want 0", irq); end
    level_in = 16'h0010; tick();
    nCmp++; if (irq !== 1'b1) begin nErr++; $display("FAIL irq_on_edge got %b want 1", irq); end
    level_in = 16'h0000; tick();
    nCmp++; if (irq !== 1'b1) begin nErr++; $display("FAIL irq_level_hold got %b want 1", irq); end
    doWrite(2'd1, 16'h0010);
    nCmp++; if (irq !== 1'b0) begin nErr++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask

  task automatic test_overrun();
    logic [15:0] d;
    logic v;
    level_in = 16'h0004; tick();
    level_in = 16'h0000; tick();
    doRead(2'd3, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL overrun_first_edge got %h want %h", d, 16'h0000); end
    level_in = 16'h0004; tick();
    level_in = 16'h0000; tick();
    doRead(2'd3, d, v);
    nCmp++; if (d !== 16'h0004) begin nErr++; $display("FAIL overrun_set got %h want %h", d, 16'h0004); end
    doWrite(2'd3, 16'h0004);
    doRead(2'd3, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL overrun_w1c got %h want %h", d, 16'h0000); end
    level_in = 16'h0004; addr = 2'd1; wr_data = 16'h0004; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; level_in = 16'h0000;
    doRead(2'd1, d, v);
    nCmp++; if (d !== 16'h0004) begin nErr++; $display("FAIL set_wins_clear got %h want %h", d, 16'h0004); end
    doRead(2'd3, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL overrun_not_on_clear got %h want %h", d, 16'h0000); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic v;
    addr = 2'd1; wr_data = 16'h0004; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    nCmp++; if (rd_data !== 16'h0004) begin nErr++; $display("FAIL rw_pre_value got %h want %h", rd_data, 16'h0004); end
    doRead(2'd1, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL rw_cleared got %h want %h", d, 16'h0000); end
    doWrite(2'd0, 16'hFFFF);
    doRead(2'd0, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL level_write_ignored got %h want %h", d, 16'h0000); end
    doRead(2'd2, d, v);
    nCmp++; if (d !== 16'h0010) begin nErr++; $display("FAIL mask_unchanged got %h want %h", d, 16'h0010); end
    doRead(2'd1, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL event_unchanged got %h want %h", d, 16'h0000); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] d;
    logic v;
    doWrite(2'd2, 16'hFFFF);
    level_in = 16'hFFFF; tick();
    nCmp++; if (irq !== 1'b1) begin nErr++; $display("FAIL all_irq got %b want 1", irq); end
    doRead(2'd1, d, v);
    nCmp++; if (d !== 16'hFFFF) begin nErr++; $display("FAIL all_events got %h want %h", d, 16'hFFFF); end
    rst_n = 1'b0;
    #1;
    nCmp++; if (rd_valid !== 1'b0) begin nErr++; $display("FAIL async_rd_valid got %b want 0", rd_valid); end
    nCmp++; if (irq !== 1'b0) begin nErr++; $display("FAIL async_irq got %b want 0", irq); end
    nCmp++; if (rd_data !== 16'h0) begin nErr++; $display("FAIL async_rd_data got %h want %h", rd_data, 16'h0); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    doRead(2'd1, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL reset_event got %h want %h", d, 16'h0000); end
    doRead(2'd2, d, v);
    nCmp++; if (d !== 16'h0000) begin nErr++; $display("FAIL reset_mask got %h want %h", d, 16'h0000); end
    nCmp++; if (irq !== 1'b0) begin nErr++; $display("FAIL rearm_irq got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_edge_capture();
    test_irq();
    test_overrun();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
